// File: rtl/rib_mem_slave.sv
// rib_mem_slave: RIB data RAM responder, 1-cycle registered reads, byte-lane writes, post-reset clear.
// Ports: clk, rst_n (async, active-low); rd_req_i/rd_addr_i read request; wr_req_i/wr_addr_i/wr_data_i/wr_sel_i
// write request; rd_data_o/rd_valid_o/rd_err_o read response; wr_err_o write miss; busy_o clearing in progress.
module rib_mem_slave #(
    parameter int          MEM_AW         = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_sel_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_err_o,
    output logic        wr_err_o,
    output logic        busy_o
);
    localparam int DEPTH = 1 << MEM_AW;
    typedef enum logic {INIT, RUN} state_t;
    state_t            state;
    logic [MEM_AW-1:0] clr_cnt;
    logic [31:0]       mem [DEPTH];
    logic              rd_hit, wr_hit, wr_en;
    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic [31:0]       wr_mask, rd_word;
    logic              unused;
    assign unused  = ^{rd_addr_i[1:0], wr_addr_i[1:0]};
    assign rd_hit  = rd_addr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
    assign wr_hit  = wr_addr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
    assign rd_idx  = rd_addr_i[MEM_AW+1:2];
    assign wr_idx  = wr_addr_i[MEM_AW+1:2];
    assign wr_en   = wr_req_i && wr_hit && state == RUN;
    assign wr_mask = {{8{wr_sel_i[3]}}, {8{wr_sel_i[2]}}, {8{wr_sel_i[1]}}, {8{wr_sel_i[0]}}};
    // write-first: a same-word write in the same cycle is merged into the returned word
    assign rd_word = (wr_en && wr_idx == rd_idx) ? (mem[rd_idx] & ~wr_mask) | (wr_data_i & wr_mask) : mem[rd_idx];
    assign busy_o  = state == INIT;
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            for (int i = 0; i < 4; i++)
                if (wr_sel_i[i]) mem[wr_idx][8*i +: 8] <= wr_data_i[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ON_RESET ? INIT : RUN;
            clr_cnt    <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
            wr_err_o   <= 1'b0;
        end else if (state == INIT) begin
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
            wr_err_o   <= 1'b0;
            clr_cnt    <= clr_cnt + MEM_AW'(1);
            if (&clr_cnt) state <= RUN;
        end else begin
            rd_valid_o <= rd_req_i;
            rd_err_o   <= rd_req_i && !rd_hit;
            wr_err_o   <= wr_req_i && !wr_hit;
            if (rd_req_i) rd_data_o <= rd_hit ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_rib_mem_slave.sv
// tb_rib_mem_slave: randomized scoreboard bench for rib_mem_slave against a word-array reference model.
module tb_rib_mem_slave;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          BIG  = 1 << 30;
    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } rsp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req_i, wr_req_i;
    logic [31:0] rd_addr_i, wr_addr_i, wr_data_i;
    logic [3:0]  wr_sel_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o, rd_err_o, wr_err_o, busy_o;
    int          cyc = 0;
    int          init_end = BIG;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_data = '0;
    logic [31:0] model [16];
    rsp_t        rq[$];
    int          wq[$];

    rib_mem_slave #(.MEM_AW(4), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_sel_i(wr_sel_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o), .wr_err_o(wr_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'd64;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom % 8)
            0: return BASE + 32'd64 + 4 * ($urandom % 4);
            1: return BASE - 32'd1 - ($urandom % 4);
            2: return $urandom;
            default: return BASE + $urandom_range(0, 63);
        endcase
    endfunction

    // Drive one request cycle and record what the model says must come back.
    task automatic req(input bit rd, input logic [31:0] ra, input bit wr, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws);
        bit   acc;
        rsp_t r;
        @(negedge clk);
        #1;
        rd_req_i  = rd;
        rd_addr_i = ra;
        wr_req_i  = wr;
        wr_addr_i = wa;
        wr_data_i = wd;
        wr_sel_i  = ws;
        acc = rst_n && cyc >= init_end;
        if (acc && wr) begin
            if (in_win(wa)) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) model[widx(wa)][8*i +: 8] = wd[8*i +: 8];
            end else
                wq.push_back(cyc + 1);
        end
        if (acc && rd) begin
            r.due  = cyc + 1;
            r.err  = !in_win(ra);
            r.data = r.err ? 32'h0 : model[widx(ra)];
            rq.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        init_end = BIG;
        last_data = '0;
        rq.delete();
        wq.delete();
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
        init_end = cyc + 16;
    endtask

    always @(negedge clk) begin
        bit   ev, ew;
        rsp_t h;
        ev = rq.size() > 0 && rq[0].due == cyc;
        ew = wq.size() > 0 && wq[0] == cyc;
        check("busy", busy_o, 32'(!rst_n || cyc < init_end));
        check("rd_valid", rd_valid_o, 32'(ev));
        check("wr_err", wr_err_o, 32'(ew));
        if (ev) begin
            h = rq.pop_front();
            check("rd_err", rd_err_o, 32'(h.err));
            check("rd_data", rd_data_o, h.data);
            last_data = h.data;
        end else begin
            check("rd_err_idle", rd_err_o, 0);
            check("rd_data_hold", rd_data_o, last_data);
        end
        if (ew) void'(wq.pop_front());
    end

    initial begin
        rst_n = 1'b0;
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        rd_addr_i = '0;
        wr_addr_i = '0;
        wr_data_i = '0;
        wr_sel_i = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        init_end = cyc + 16;
        for (int i = 0; i < 4; i++) req(1, BASE + 4 * i, 1, BASE + 4 * i, 32'hFFFF_FFFF, 4'hF);
        reset_pulse(2);
        for (int i = 0; i < 16; i++) req(1, BASE + 4 * i, 1, BASE + 4 * (i % 2), 32'hA5A5_0000 | i, 4'hF);
        for (int i = 0; i < 16; i++) req(1, BASE + 4 * i, 0, 0, 0, 0);
        req(0, 0, 1, BASE + 8, 32'hDEAD_BEEF, 4'b1111);
        req(1, BASE + 8, 0, 0, 0, 0);
        req(1, BASE + 32'hA, 0, 0, 0, 0);
        req(0, 0, 1, BASE + 8, 32'h0000_AA00, 4'b0010);
        req(1, BASE + 8, 0, 0, 0, 0);
        req(1, BASE + 8, 1, BASE + 8, 32'h1234_5678, 4'b1100);
        req(1, BASE + 8, 1, BASE + 4, 32'hCAFE_F00D, 4'b0000);
        idle(2);
        req(1, 32'h2000_0000, 0, 0, 0, 0);
        req(0, 0, 1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        req(1, BASE, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, wa;
            ra = rnd_addr();
            wa = ($urandom % 4 == 0) ? ra : rnd_addr();
            req(1'($urandom), ra, ($urandom % 3) == 0, wa, $urandom, 4'($urandom));
        end
        idle(3);
        check("drain", 32'(rq.size() + wq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
